// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, status bit positions and the serial FSM state type.
package uart_mmio_pkg;

    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_MSB = 15;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    // Assemble the STATUS word; every bit not listed here reads as 0.
    function automatic logic [31:0] packStatus(input logic       full,
                                               input logic       empty,
                                               input logic       busy,
                                               input logic       ovf,
                                               input logic [7:0] count);
        logic [31:0] s;
        s = '0;
        s[ST_FULL_BIT]                = full;
        s[ST_EMPTY_BIT]               = empty;
        s[ST_BUSY_BIT]                = busy;
        s[ST_OVF_BIT]                 = ovf;
        s[ST_COUNT_MSB:ST_COUNT_LSB]  = count;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus strobes seen by the UART, plus its decode/readback outputs.
interface uart_tx_mmio_if;

    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        memwidth;
    logic        hit;
    logic [31:0] rdata;

    modport master (
        output memwrite, dataadr, writedata, memwidth,
        input  hit, rdata
    );

    modport slave (
        input  memwrite, dataadr, writedata, memwidth,
        output hit, rdata
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rdata_o is the head entry whenever non-empty.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             popOk;
    logic             pushOk;

    assign popOk   = pop_i && (count_q != '0);
    assign pushOk  = push_i && ((count_q != (AW+1)'(DEPTH)) || popOk);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];

    // Storage array; no reset needed since count gates validity.
    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({pushOk, popOk})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter. Stores to TXDATA queue a byte in the
// FIFO; STATUS reads back full/empty/busy/overflow/count combinationally.
module uart_tx_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_mmio_if.slave  bus,
    output logic           tx
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam int             FW        = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]  LAST_TICK = CW'(CLKS_PER_BIT - 1);

    uart_state_t    state_q;
    logic [CW-1:0]  bitCnt_q;
    logic [2:0]     bitIdx_q;
    logic [7:0]     shift_q;
    logic           tx_q;
    logic           overflow_q;
    logic           overflow_d;

    logic           wrTxData;
    logic           wrStatus;
    logic           lastTick;
    logic           fifoPop;
    logic           pushDropped;
    logic           fifoFull;
    logic           fifoEmpty;
    logic [FW:0]    fifoCount;
    logic [7:0]     fifoData;
    logic           unusedBits;

    assign wrTxData    = bus.memwrite && (bus.dataadr == BASE_ADDR + TXDATA_OFS);
    assign wrStatus    = bus.memwrite && (bus.dataadr == BASE_ADDR + STATUS_OFS);
    assign lastTick    = (bitCnt_q == LAST_TICK);
    assign fifoPop     = !fifoEmpty && ((state_q == IDLE) || ((state_q == STOP) && lastTick));
    assign pushDropped = wrTxData && fifoFull && !fifoPop;

    // Only the low byte is transmitted and sb/sw behave identically.
    assign unusedBits  = ^{bus.writedata[31:8], bus.memwidth};

    assign bus.hit   = (bus.dataadr[31:3] == BASE_ADDR[31:3]);
    assign bus.rdata = (bus.dataadr == BASE_ADDR + STATUS_OFS)
                     ? packStatus(fifoFull, fifoEmpty, (state_q != IDLE), overflow_q, 8'(fifoCount))
                     : '0;
    assign tx        = tx_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (wrTxData),
        .pop_i   (fifoPop),
        .wdata_i (bus.writedata[7:0]),
        .rdata_o (fifoData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Sticky overflow: a dropped push outranks a clearing STATUS write.
    always_comb begin
        overflow_d = overflow_q;
        if (pushDropped) begin
            overflow_d = 1'b1;
        end else if (wrStatus) begin
            overflow_d = 1'b0;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    // Serial framer: start bit, 8 data bits LSB first, stop bit; the next
    // queued byte is popped on the last stop tick so frames run contiguously.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q     <= 1'b1;
                    bitCnt_q <= '0;
                    if (!fifoEmpty) begin
                        shift_q <= fifoData;
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (lastTick) begin
                        bitCnt_q <= '0;
                        bitIdx_q <= '0;
                        state_q  <= DATA;
                        tx_q     <= shift_q[0];
                    end else begin
                        bitCnt_q <= bitCnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (lastTick) begin
                        bitCnt_q <= '0;
                        if (bitIdx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                            shift_q  <= {1'b0, shift_q[7:1]};
                            tx_q     <= shift_q[1];
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (lastTick) begin
                        bitCnt_q <= '0;
                        if (!fifoEmpty) begin
                            shift_q <= fifoData;
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed testbench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] rxQ [$];

    uart_tx_mmio_if bus();

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Independent serial receiver: frames start on the first low sample,
    // data bits are sampled mid-bit, decoded bytes land in rxQ.
    initial begin : rxModel
        int         rxCnt;
        logic       rxActive;
        logic [7:0] rxByte;
        rxActive = 1'b0;
        rxCnt    = 0;
        rxByte   = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                rxActive = 1'b0;
            end else if (!rxActive) begin
                if (tx === 1'b0) begin
                    rxActive = 1'b1;
                    rxCnt    = 0;
                end
            end else begin
                rxCnt++;
                if (rxCnt >= 6 && rxCnt <= 34 && ((rxCnt - 6) % 4) == 0) begin
                    rxByte[3'((rxCnt - 6) / 4)] = tx;
                end
                if (rxCnt == 38) rxQ.push_back(rxByte);
                if (rxCnt == 39) rxActive = 1'b0;
            end
        end
    end

    // Global time limit so the bench always ends.
    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // One bus write cycle; leaves the address parked on STATUS afterwards.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic width);
        bus.memwrite  = 1'b1;
        bus.dataadr   = addr;
        bus.writedata = data;
        bus.memwidth  = width;
        @(negedge clk);
        bus.memwrite  = 1'b0;
        bus.dataadr   = BASE + 32'h4;
        #1;
    endtask

    task automatic waitNegedges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset;
        reset        = 1'b1;
        bus.memwrite = 1'b0;
        bus.dataadr  = BASE + 32'h4;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset         = 1'b1;
        bus.memwrite  = 1'b0;
        bus.dataadr   = BASE + 32'h4;
        bus.writedata = '0;
        bus.memwidth  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_tx: got %b expected 1", tx);
        end
        checks++;
        if (bus.rdata !== 32'h0000_0002) begin
            failures++; $display("[TB] FAIL reset_status: got %h expected 00000002", bus.rdata);
        end
        checks++;
        if (bus.hit !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_hit: got %b expected 1", bus.hit);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_byte;
        logic [7:0] b;
        logic       exp;
        b = 8'hA5;
        rxQ.delete();
        applyStimulus(BASE, 32'h1234_56A5, 1'b0);
        checks++;
        if (bus.rdata !== 32'h0000_0100) begin
            failures++; $display("[TB] FAIL single_status_after_push: got %h expected 00000100", bus.rdata);
        end
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       exp = 1'b0;
            else if (i < 36) exp = b[3'((i - 4) / 4)];
            else             exp = 1'b1;
            checks++;
            if (tx !== exp) begin
                failures++; $display("[TB] FAIL single_tx[%0d]: got %b expected %b", i, tx, exp);
            end
            if (i == 0) begin
                checks++;
                if (bus.rdata !== 32'h0000_0006) begin
                    failures++; $display("[TB] FAIL single_status_busy: got %h expected 00000006", bus.rdata);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (bus.rdata !== 32'h0000_0002 || tx !== 1'b1) begin
            failures++; $display("[TB] FAIL single_idle: got status %h tx %b expected 00000002 tx 1", bus.rdata, tx);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b;
        logic       exp;
        int         j;
        doReset();
        rxQ.delete();
        applyStimulus(BASE, 32'hFFFF_FF41, 1'b1);
        applyStimulus(BASE, 32'hABCD_EF42, 1'b1);
        for (int i = 0; i < 80; i++) begin
            b = (i < 40) ? 8'h41 : 8'h42;
            j = i % 40;
            if (j < 4)       exp = 1'b0;
            else if (j < 36) exp = b[3'((j - 4) / 4)];
            else             exp = 1'b1;
            checks++;
            if (tx !== exp) begin
                failures++; $display("[TB] FAIL b2b_tx[%0d]: got %b expected %b", i, tx, exp);
            end
            checks++;
            if (bus.rdata[2] !== 1'b1) begin
                failures++; $display("[TB] FAIL b2b_busy[%0d]: got %b expected 1", i, bus.rdata[2]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.rdata !== 32'h0000_0002) begin
            failures++; $display("[TB] FAIL b2b_idle_status: got %h expected 00000002", bus.rdata);
        end
        checks++;
        if (rxQ.size() != 2 || rxQ[0] !== 8'h41 || rxQ[1] !== 8'h42) begin
            failures++; $display("[TB] FAIL b2b_rx: got %0d bytes expected 2 bytes 41 42", rxQ.size());
        end
    endtask

    task automatic test_overflow;
        logic [7:0] exp [5];
        int         guard;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        doReset();
        rxQ.delete();
        applyStimulus(BASE, 32'h0000_0011, 1'b0);
        @(negedge clk);
        applyStimulus(BASE, 32'h0000_0022, 1'b0);
        applyStimulus(BASE, 32'h0000_0033, 1'b0);
        applyStimulus(BASE, 32'h0000_0044, 1'b0);
        applyStimulus(BASE, 32'h0000_0055, 1'b0);
        applyStimulus(BASE, 32'h0000_0066, 1'b0);
        checks++;
        if (bus.rdata !== 32'h0000_040D) begin
            failures++; $display("[TB] FAIL ovf_status: got %h expected 0000040d", bus.rdata);
        end
        applyStimulus(BASE + 32'h4, 32'h0000_0000, 1'b0);
        checks++;
        if (bus.rdata !== 32'h0000_0405) begin
            failures++; $display("[TB] FAIL ovf_clear: got %h expected 00000405", bus.rdata);
        end
        guard = 0;
        while (bus.rdata[2] !== 1'b0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 400) begin
            failures++; $display("[TB] FAIL ovf_drain_timeout: got %0d cycles expected under 400", guard);
        end
        waitNegedges(50);
        checks++;
        if (rxQ.size() != 5) begin
            failures++; $display("[TB] FAIL ovf_rx_count: got %0d expected 5", rxQ.size());
        end
        for (int i = 0; i < 5 && i < rxQ.size(); i++) begin
            checks++;
            if (rxQ[i] !== exp[i]) begin
                failures++; $display("[TB] FAIL ovf_rx[%0d]: got %h expected %h", i, rxQ[i], exp[i]);
            end
        end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] exp [6];
        int         guard;
        exp = '{8'h01, 8'h80, 8'hFF, 8'h3C, 8'hC3, 8'h99};
        doReset();
        rxQ.delete();
        applyStimulus(BASE, 32'h0000_0001, 1'b0);
        @(negedge clk);
        applyStimulus(BASE, 32'h0000_0080, 1'b0);
        applyStimulus(BASE, 32'h0000_00FF, 1'b0);
        applyStimulus(BASE, 32'h0000_003C, 1'b0);
        applyStimulus(BASE, 32'h0000_00C3, 1'b0);
        waitNegedges(35);
        checks++;
        if (bus.rdata !== 32'h0000_0405 || tx !== 1'b1) begin
            failures++; $display("[TB] FAIL fpp_before: got status %h tx %b expected 00000405 tx 1", bus.rdata, tx);
        end
        applyStimulus(BASE, 32'h0000_0099, 1'b0);
        checks++;
        if (bus.rdata !== 32'h0000_0405) begin
            failures++; $display("[TB] FAIL fpp_after: got %h expected 00000405", bus.rdata);
        end
        checks++;
        if (tx !== 1'b0) begin
            failures++; $display("[TB] FAIL fpp_next_start: got %b expected 0", tx);
        end
        guard = 0;
        while (bus.rdata[2] !== 1'b0 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 600) begin
            failures++; $display("[TB] FAIL fpp_drain_timeout: got %0d cycles expected under 600", guard);
        end
        waitNegedges(50);
        checks++;
        if (rxQ.size() != 6) begin
            failures++; $display("[TB] FAIL fpp_rx_count: got %0d expected 6", rxQ.size());
        end
        for (int i = 0; i < 6 && i < rxQ.size(); i++) begin
            checks++;
            if (rxQ[i] !== exp[i]) begin
                failures++; $display("[TB] FAIL fpp_rx[%0d]: got %h expected %h", i, rxQ[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic sawLow;
        doReset();
        rxQ.delete();
        applyStimulus(BASE, 32'h0000_00A5, 1'b0);
        applyStimulus(BASE, 32'h0000_0011, 1'b0);
        applyStimulus(BASE, 32'h0000_0022, 1'b0);
        waitNegedges(15);
        checks++;
        if (bus.rdata !== 32'h0000_0204 || tx !== 1'b0) begin
            failures++; $display("[TB] FAIL mid_before: got status %h tx %b expected 00000204 tx 0", bus.rdata, tx);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            failures++; $display("[TB] FAIL mid_tx: got %b expected 1", tx);
        end
        checks++;
        if (bus.rdata !== 32'h0000_0002) begin
            failures++; $display("[TB] FAIL mid_status: got %h expected 00000002", bus.rdata);
        end
        @(negedge clk);
        reset  = 1'b0;
        sawLow = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) sawLow = 1'b1;
        end
        checks++;
        if (sawLow !== 1'b0 || rxQ.size() != 0) begin
            failures++; $display("[TB] FAIL mid_no_frames: got lowSeen %b rx %0d expected 0 0", sawLow, rxQ.size());
        end
        checks++;
        if (bus.rdata !== 32'h0000_0002) begin
            failures++; $display("[TB] FAIL mid_status_later: got %h expected 00000002", bus.rdata);
        end
    endtask

    task automatic test_decode;
        doReset();
        rxQ.delete();
        bus.memwrite  = 1'b1;
        bus.writedata = 32'h0000_0077;
        bus.memwidth  = 1'b0;
        bus.dataadr   = BASE + 32'h8;
        #1;
        checks++;
        if (bus.hit !== 1'b0) begin
            failures++; $display("[TB] FAIL dec_hit_base8: got %b expected 0", bus.hit);
        end
        @(negedge clk);
        bus.dataadr = 32'h0000_0000;
        #1;
        checks++;
        if (bus.hit !== 1'b0) begin
            failures++; $display("[TB] FAIL dec_hit_zero: got %b expected 0", bus.hit);
        end
        @(negedge clk);
        bus.dataadr  = BASE + 32'h1;
        bus.memwidth = 1'b1;
        #1;
        checks++;
        if (bus.hit !== 1'b1) begin
            failures++; $display("[TB] FAIL dec_hit_base1: got %b expected 1", bus.hit);
        end
        @(negedge clk);
        bus.dataadr = BASE + 32'h7;
        #1;
        checks++;
        if (bus.hit !== 1'b1) begin
            failures++; $display("[TB] FAIL dec_hit_base7: got %b expected 1", bus.hit);
        end
        @(negedge clk);
        bus.memwrite = 1'b0;
        bus.dataadr  = BASE;
        #1;
        checks++;
        if (bus.rdata !== 32'h0 || bus.hit !== 1'b1) begin
            failures++; $display("[TB] FAIL dec_txdata_read: got rdata %h hit %b expected 00000000 hit 1", bus.rdata, bus.hit);
        end
        bus.dataadr = BASE - 32'h4;
        #1;
        checks++;
        if (bus.hit !== 1'b0 || bus.rdata !== 32'h0) begin
            failures++; $display("[TB] FAIL dec_below: got hit %b rdata %h expected hit 0 rdata 00000000", bus.hit, bus.rdata);
        end
        bus.dataadr = BASE + 32'h4;
        waitNegedges(5);
        checks++;
        if (bus.rdata !== 32'h0000_0002 || tx !== 1'b1 || rxQ.size() != 0) begin
            failures++; $display("[TB] FAIL dec_no_push: got status %h tx %b rx %0d expected 00000002 tx 1 rx 0", bus.rdata, tx, rxQ.size());
        end
    endtask

    // Scenario sequence.
    initial begin : mainSeq
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_frame();
        test_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
